// File: rtl/recip_nr_sched.sv
// -----------------------------------------------------------------------------
// recip_nr_sched
//
// Purpose
//   Scheduler and sequencer for a shared Newton-Raphson reciprocal unit. It
//   round-robin arbitrates NREQ requesters and latches the winning divisor D
//   (Q32.32). It seeds X from the leading one of the integer part of D. It then
//   runs one step X <= X*(2 - D*X) per cycle until X stops changing or ITER_MAX
//   steps have been taken. The result is returned as Q0.32 together with the
//   owning requester's tag. Only one job is in flight at any time.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   req_valid    [NREQ]       request valid, one bit per requester
//   req_ready    [NREQ]       request accepted on valid&ready, at most one bit high
//   req_d        [NREQ*64]    divisor per requester, slice i = [64i+63:64i]
//   resp_valid   result valid, held until resp_ready
//   resp_ready   consumer accepts result
//   resp_x       [32]         reciprocal, Q0.32 unsigned
//   resp_id      [ID_W]       requester that owns resp_x
//   resp_iters   [4]          NR iterations executed
//   resp_err     divisor < 1.0, result saturated
//   busy         high whenever the FSM is not IDLE
//   dbg_state_o  [2]          current FSM state (IDLE=0, SEED=1, ITER=2, DONE=3)
//
// Handshake
//   Both interfaces use valid/ready. A transfer happens on the rising edge
//   where valid and ready are both high. A requester keeps valid and its data
//   stable until that edge. The producer keeps resp_valid and the resp_*
//   fields stable until that edge. Ready never depends on anything the
//   requester does after valid is raised, except its own valid bit.
// -----------------------------------------------------------------------------
module recip_nr_sched #(
    parameter int NREQ     = 4,
    parameter int ID_W     = 2,
    parameter int ITER_MAX = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*64-1:0]   req_d,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [31:0]          resp_x,
    output logic [ID_W-1:0]      resp_id,
    output logic [3:0]           resp_iters,
    output logic                 resp_err,
    output logic                 busy,
    output logic [1:0]           dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEED = 2'd1,
        S_ITER = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam logic [ID_W:0] NREQ_W   = (ID_W+1)'(NREQ);
    localparam logic [3:0]    ITER_LIM = 4'(ITER_MAX);
    localparam logic [63:0]   D_ONE    = 64'h0000_0001_0000_0000;
    // Constant 2.0 at the Q32.64 scale of D*X.
    localparam logic [96:0]   TWO_Q64  = 97'h2_0000_0000_0000_0000;

    state_e          state_q, state_d;
    logic [ID_W-1:0] rr_q, rr_d;
    logic [63:0]     d_q, d_d;
    logic [ID_W-1:0] tag_q, tag_d;
    logic [31:0]     x_q, x_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [31:0]     resp_x_q, resp_x_d;
    logic [3:0]      resp_iters_q, resp_iters_d;
    logic            resp_err_q, resp_err_d;

    // ------------------------------------------------------------------
    // Round-robin grant: first valid requester at or above rr_q, with wrap.
    // Grants are suppressed while reset is asserted, so that req_ready
    // reads 0 during reset even when requesters are already valid.
    // ------------------------------------------------------------------
    logic            grant_vld;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W:0]   cand;
    logic [ID_W:0]   rr_inc;
    logic [ID_W-1:0] rr_next;
    logic [63:0]     grant_d;

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_q} + (ID_W+1)'(k);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (!grant_vld && reset && req_valid[cand[ID_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        rr_inc = {1'b0, grant_idx} + (ID_W+1)'(1);
        if (rr_inc == NREQ_W) begin
            rr_inc = '0;
        end
        rr_next = rr_inc[ID_W-1:0];
    end

    assign grant_d = req_d[64*grant_idx +: 64];

    // ------------------------------------------------------------------
    // Seed: X = 2^-(p+1), where p is the msb index of the integer part of D.
    // This puts D*X in [0.5, 1), so the iteration approaches 1/D from below
    // and 2 - D*X stays positive.
    // ------------------------------------------------------------------
    logic [4:0]  msb_p;
    logic [31:0] seed_x;

    always_comb begin
        msb_p = '0;
        for (int i = 0; i < 32; i++) begin
            if (d_q[32+i]) begin
                msb_p = 5'(i);
            end
        end
    end

    assign seed_x = 32'h8000_0000 >> msb_p;

    // ------------------------------------------------------------------
    // One Newton-Raphson step at full width.
    // P = D*X (Q32.64), E = 2 - P, Xn = (X*E) >> 64 with saturation.
    // ------------------------------------------------------------------
    logic [95:0] prod_p;
    logic [96:0] err_e;
    logic        e_oor;
    logic [97:0] xe;
    logic [33:0] xn_wide;
    logic [31:0] x_next;
    logic [3:0]  cnt_inc;

    assign prod_p  = {32'b0, d_q} * {64'b0, x_q};
    assign err_e   = TWO_Q64 - {1'b0, prod_p};
    // E is in (1, 2] whenever the seed invariant holds. If E ever left that
    // range, X is held instead, which ends the job as converged.
    assign e_oor   = |err_e[96:66];
    assign xe      = {32'b0, err_e[65:0]} * {66'b0, x_q};
    assign xn_wide = 34'(xe >> 64);
    assign cnt_inc = cnt_q + 4'd1;

    always_comb begin
        if (e_oor) begin
            x_next = x_q;
        end else if (|xn_wide[33:32]) begin
            x_next = 32'hFFFF_FFFF;
        end else begin
            x_next = xn_wide[31:0];
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and datapath next values.
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        d_d          = d_q;
        tag_d        = tag_q;
        x_d          = x_q;
        cnt_d        = cnt_q;
        resp_x_d     = resp_x_q;
        resp_iters_d = resp_iters_q;
        resp_err_d   = resp_err_q;
        req_ready    = '0;

        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    req_ready[grant_idx] = 1'b1;
                    d_d     = grant_d;
                    tag_d   = grant_idx;
                    rr_d    = rr_next;
                    state_d = S_SEED;
                end
            end
            S_SEED: begin
                if (d_q[63:32] == 32'd0) begin
                    // D < 1.0: the reciprocal does not fit in Q0.32.
                    resp_x_d     = 32'hFFFF_FFFF;
                    resp_err_d   = 1'b1;
                    resp_iters_d = 4'd0;
                    state_d      = S_DONE;
                end else if (d_q == D_ONE) begin
                    // Exactly 1.0 saturates without being an error.
                    resp_x_d     = 32'hFFFF_FFFF;
                    resp_err_d   = 1'b0;
                    resp_iters_d = 4'd0;
                    state_d      = S_DONE;
                end else begin
                    x_d     = seed_x;
                    cnt_d   = 4'd0;
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                x_d   = x_next;
                cnt_d = cnt_inc;
                if ((x_next == x_q) || (cnt_inc == ITER_LIM)) begin
                    resp_x_d     = x_next;
                    resp_err_d   = 1'b0;
                    resp_iters_d = cnt_inc;
                    state_d      = S_DONE;
                end
            end
            S_DONE: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            rr_q         <= '0;
            d_q          <= '0;
            tag_q        <= '0;
            x_q          <= '0;
            cnt_q        <= '0;
            resp_x_q     <= '0;
            resp_iters_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            d_q          <= d_d;
            tag_q        <= tag_d;
            x_q          <= x_d;
            cnt_q        <= cnt_d;
            resp_x_q     <= resp_x_d;
            resp_iters_q <= resp_iters_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign resp_valid  = (state_q == S_DONE);
    assign busy        = (state_q != S_IDLE);
    assign resp_x      = resp_x_q;
    assign resp_id     = tag_q;
    assign resp_iters  = resp_iters_q;
    assign resp_err    = resp_err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_recip_nr_sched.sv
// -----------------------------------------------------------------------------
// tb_recip_nr_sched
//
// Bench for recip_nr_sched. Driver tasks present divisors. Each accepted job
// pushes its expected response onto exp_q, computed as
// min(floor(2^64/D), 2^32-1) with err/special flags. A negedge monitor pops
// and compares every response handshake. Directed sequences cover error and
// 1.0 paths, round-robin order, backpressure, and reset mid-job. These are
// followed by random jobs.
// -----------------------------------------------------------------------------
module tb_recip_nr_sched;

    localparam int NREQ     = 4;
    localparam int ID_W     = 2;
    localparam int ITER_MAX = 6;
    localparam int EW       = 36; // {special, err, id[1:0], x[31:0]}

    // ---------------- clock / reset ----------------
    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*64-1:0]   req_d;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [31:0]          resp_x;
    logic [ID_W-1:0]      resp_id;
    logic [3:0]           resp_iters;
    logic                 resp_err;
    logic                 busy;
    logic [1:0]           dbg_state_o;

    always #5 clk = ~clk;

    recip_nr_sched #(
        .NREQ     (NREQ),
        .ID_W     (ID_W),
        .ITER_MAX (ITER_MAX)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_d       (req_d),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_x      (resp_x),
        .resp_id     (resp_id),
        .resp_iters  (resp_iters),
        .resp_err    (resp_err),
        .busy        (busy),
        .dbg_state_o (dbg_state_o)
    );

    // ---------------- scoreboard state ----------------
    int unsigned   n_vec = 0;
    int unsigned   n_bad = 0;
    logic [EW-1:0] exp_q[$];
    int            grant_log[$];
    logic [EW-1:0] mon_e;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp, input logic [63:0] tol = 64'd0);
        logic [63:0] diff;
        n_vec++;
        diff = (obs > exp) ? (obs - exp) : (exp - obs);
        if (diff > tol) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (tol %0d) at %0t", tag, obs, exp, tol, $time);
        end
    endtask

    function automatic logic [EW-1:0] model(input logic [63:0] d, input logic [1:0] id);
        logic [127:0] q;
        logic [31:0]  x;
        logic         err;
        logic         sp;
        if (d[63:32] == 32'd0) begin
            x   = 32'hFFFF_FFFF;
            err = 1'b1;
            sp  = 1'b1;
        end else begin
            q   = (128'h1 << 64) / {64'h0, d};
            x   = (q > 128'hFFFF_FFFF) ? 32'hFFFF_FFFF : q[31:0];
            err = 1'b0;
            sp  = (d == 64'h1_0000_0000);
        end
        return {sp, err, id, x};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send(input int idx, input logic [63:0] d, input bit push);
        int t;
        t = 0;
        req_d[idx*64 +: 64] = d;
        req_valid[idx] = 1'b1;
        @(negedge clk);
        while (!req_ready[idx] && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready[idx]) begin
            chk("accept_timeout", 64'd0, 64'd1);
            req_valid[idx] = 1'b0;
            return;
        end
        if (push) exp_q.push_back(model(d, 2'(idx)));
        grant_log.push_back(idx);
        @(posedge clk);
        #1;
        req_valid[idx] = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        repeat (2) @(negedge clk);
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (reset) begin
            chk("ready_onehot0", 64'($onehot0(req_ready)), 64'd1);
            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp", 64'd1, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("resp_x", 64'(resp_x), 64'(mon_e[31:0]), mon_e[35] ? 64'd0 : 64'd2);
                    chk("resp_id", 64'(resp_id), 64'(mon_e[33:32]));
                    chk("resp_err", 64'(resp_err), 64'(mon_e[34]));
                    if (mon_e[35])
                        chk("iters_zero", 64'(resp_iters), 64'd0);
                    else
                        chk("iters_range", 64'(resp_iters >= 4'd1 && resp_iters <= 4'(ITER_MAX)), 64'd1);
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] x_snap;
        logic [31:0] hi;
        logic [31:0] lo;
        int          t;
        int          idx;

        req_valid  = '0;
        req_d      = '0;
        resp_ready = 1'b1;
        reset      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_resp_x", 64'(resp_x), 64'd0);
        chk("rst_resp_id", 64'(resp_id), 64'd0);
        chk("rst_resp_iters", 64'(resp_iters), 64'd0);
        chk("rst_resp_err", 64'(resp_err), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_state", 64'(dbg_state_o), 64'd0);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // 1: D = 2.0 on requester 0
        send(0, 64'h2_0000_0000, 1'b1);
        wait_drain();

        // 2: D = 0.5 -> error, response two cycles after accept
        send(1, 64'h0_8000_0000, 1'b1);
        @(negedge clk);
        chk("t2_seed_cycle_valid", 64'(resp_valid), 64'd0);
        @(negedge clk);
        chk("t2_valid_after_2", 64'(resp_valid), 64'd1);
        wait_drain();

        // 3: D = 1.0 -> saturate, no error
        send(2, 64'h1_0000_0000, 1'b1);
        wait_drain();

        // one job on requester 3 brings the round-robin pointer back to 0
        send(3, {32'($urandom_range(200, 2)), 32'($urandom())}, 1'b1);
        wait_drain();

        // 4: all four valid together -> granted 0,1,2,3
        grant_log.delete();
        fork
            send(0, 64'h3_0000_0000, 1'b1);
            send(1, 64'h5_0000_0000, 1'b1);
            send(2, 64'h7_0000_0000, 1'b1);
            send(3, 64'hA_0000_0000, 1'b1);
        join
        wait_drain();
        chk("t4_grant_count", 64'(grant_log.size()), 64'd4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            chk("t4_grant_order", 64'(grant_log[i]), 64'(i));

        // 5: backpressure with requester 1 pending
        resp_ready = 1'b0;
        send(0, 64'h6_0000_0000, 1'b1);
        fork
            send(1, 64'h9_0000_0000, 1'b1);
        join_none
        t = 0;
        @(negedge clk);
        while (!resp_valid && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("t5_resp_seen", 64'(resp_valid), 64'd1);
        x_snap = resp_x;
        repeat (10) begin
            @(negedge clk);
            chk("t5_valid_held", 64'(resp_valid), 64'd1);
            chk("t5_x_stable", 64'(resp_x), 64'(x_snap));
            chk("t5_x_value", 64'(resp_x), 64'h2AAA_AAAA, 64'd2);
            chk("t5_id_held", 64'(resp_id), 64'd0);
            chk("t5_req_ready_zero", 64'(req_ready), 64'd0);
            chk("t5_busy", 64'(busy), 64'd1);
        end
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t5_req1_grant_next", 64'(req_ready[1]), 64'd1);
        wait_drain();

        // 6: reset during ITER discards the job
        send(0, 64'h3_0000_0000, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("t6_in_iter", 64'(dbg_state_o), 64'd2);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_resp_x", 64'(resp_x), 64'd0);
        chk("t6_rst_resp_iters", 64'(resp_iters), 64'd0);
        chk("t6_rst_resp_id", 64'(resp_id), 64'd0);
        req_valid[2] = 1'b1;
        #1;
        chk("t6_rst_req_ready", 64'(req_ready), 64'd0);
        req_valid[2] = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        repeat (12) begin
            @(negedge clk);
            chk("t6_no_stale_resp", 64'(resp_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        send(0, 64'h4_0000_0000, 1'b1);
        wait_drain();

        // random jobs with short random response stalls
        repeat (12) begin
            idx = $urandom_range(NREQ - 1, 0);
            hi  = $urandom() >> $urandom_range(31, 0);
            lo  = $urandom();
            resp_ready = 1'b0;
            send(idx, {hi, lo}, 1'b1);
            repeat ($urandom_range(4, 0)) @(posedge clk);
            #1;
            resp_ready = 1'b1;
            wait_drain();
        end

        if (exp_q.size() != 0) chk("leftover_expected", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
